// File: rtl/macc_pair_sched.sv
// Dual-neuron MACC scheduler: issues N_INPUTS operand reads and accumulates the
// two pipelined products. Define MACC_PAIR_SCHED_SAT_EN for saturating accumulators and the sat flag.
module macc_pair_sched #(
  parameter int WIDTH    = 8,
  parameter int N_INPUTS = 16,
  parameter int PIPE_LAT = 3,
  parameter int ACC_W    = 2*WIDTH + $clog2(N_INPUTS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic [$clog2(N_INPUTS)-1:0]   rd_addr,
  output logic                          issue_valid,
  input  logic signed [2*WIDTH-1:0]     ji_in,
  input  logic signed [2*WIDTH-1:0]     ki_in,
  output logic                          busy,
  output logic                          done,
`ifdef MACC_PAIR_SCHED_SAT_EN
  output logic                          sat,
`endif
  output logic signed [ACC_W-1:0]       acc_j,
  output logic signed [ACC_W-1:0]       acc_k
);

  localparam int IW = $clog2(N_INPUTS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [IW-1:0]            index;
  logic [PIPE_LAT-1:0]      vld;
  logic [PIPE_LAT:0]        vld_shift;
  logic                     retire;
  logic                     last_issue;
  logic signed [ACC_W-1:0]  ext_j, ext_k;
  logic signed [ACC_W-1:0]  nxt_j, nxt_k;

  // index stops at the last entry so rd_addr keeps its final value after ISSUE
  assign rd_addr    = index;
  assign last_issue = (index == IW'(N_INPUTS - 1));
  assign vld_shift  = {vld, issue_valid};
  assign retire     = vld[PIPE_LAT-1];
  assign ext_j      = ACC_W'(ji_in);
  assign ext_k      = ACC_W'(ki_in);

`ifdef MACC_PAIR_SCHED_SAT_EN
  logic ovf_j, ovf_k;

  function automatic logic signed [ACC_W-1:0] sat_add(
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic                    ovf
  );
    logic signed [ACC_W:0] s;
    s   = (ACC_W+1)'(a) + (ACC_W+1)'(b);
    ovf = (s[ACC_W] != s[ACC_W-1]);
    if (!ovf)          return s[ACC_W-1:0];
    else if (s[ACC_W]) return {1'b1, {(ACC_W-1){1'b0}}};
    else               return {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  always_comb begin
    nxt_j = sat_add(acc_j, ext_j, ovf_j);
    nxt_k = sat_add(acc_k, ext_k, ovf_k);
  end
`else
  assign nxt_j = acc_j + ext_j;
  assign nxt_k = acc_k + ext_k;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nxt   = state;
    issue_valid = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        issue_valid = 1'b1;
        if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        // leave once the only product left in flight is the one retiring now
        if ((vld << 1) == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      index <= '0;
      vld   <= '0;
      acc_j <= '0;
      acc_k <= '0;
`ifdef MACC_PAIR_SCHED_SAT_EN
      sat   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      vld   <= vld_shift[PIPE_LAT-1:0];
      if (state == IDLE && start) begin
        index <= '0;
        acc_j <= '0;
        acc_k <= '0;
`ifdef MACC_PAIR_SCHED_SAT_EN
        sat   <= 1'b0;
`endif
      end else begin
        if (state == ISSUE && !last_issue) index <= index + IW'(1);
        if (retire) begin
          acc_j <= nxt_j;
          acc_k <= nxt_k;
`ifdef MACC_PAIR_SCHED_SAT_EN
          sat   <= sat | ovf_j | ovf_k;
`endif
        end
      end
    end
  end

endmodule

// File: doc/macc_pair_sched.md
MACC_PAIR_SCHED -- requirements
Module: macc_pair_sched

Interface
Parameters:
REQ-001 SHALL have parameter WIDTH, default 8: operand width of weight_j, weight_k and input_i; legal range 1..8.
REQ-002 SHALL have parameter N_INPUTS, default 16: input/weight-pair count per neuron pair; legal range 2..256.
REQ-003 SHALL have parameter PIPE_LAT, default 3: macc pipeline depth in cycles; legal range 1..8.
REQ-004 SHALL have parameter ACC_W, default 2*WIDTH+$clog2(N_INPUTS): accumulator width; must be at least 2*WIDTH.

Ports (one clock; reset is synchronous and active-high):
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  begins one neuron-pair computation; sampled only in IDLE.
REQ-008 rd_addr  out  $clog2(N_INPUTS)  index into the weight/input memory; that memory presents weight_j/weight_k/input_i to the macc in the same cycle.
REQ-009 issue_valid  out  1  high when rd_addr selects a live operand set for the macc this cycle.
REQ-010 ji_in  in  2*WIDTH signed  truncated macc product weight_j*input_i.
REQ-011 ki_in  in  2*WIDTH signed  truncated macc product weight_k*input_i.
REQ-012 busy  out  1  high in ISSUE, DRAIN and DONE.
REQ-013 done  out  1  one-cycle pulse when acc_j/acc_k are final.
REQ-014 acc_j  out  ACC_W signed  sum of ji over all N_INPUTS products.
REQ-015 acc_k  out  ACC_W signed  sum of ki over all N_INPUTS products.
REQ-016 sat  out  1  sticky saturation flag; present only with the macro (see REQ-033).

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, DRAIN and DONE.
REQ-018 IDLE with start=1: go to ISSUE; clear acc_j, acc_k, the index and sat; otherwise stay in IDLE.
REQ-019 ISSUE: issue_valid=1 and rd_addr=index; index increments each cycle; after the cycle with index=N_INPUTS-1, go to DRAIN.
REQ-020 Outside ISSUE: issue_valid=0 and rd_addr holds its last value.
REQ-021 A PIPE_LAT-deep valid shift register SHALL track in-flight products; an issue in cycle t retires in cycle t+PIPE_LAT.
REQ-022 On retire, the block SHALL sign-extend ji_in/ki_in to ACC_W and add them to acc_j/acc_k; ji_in/ki_in are ignored in any cycle without a retire.
REQ-023 DRAIN: stay until the valid shift register is empty and the final retire has been accumulated, then go to DONE.
REQ-024 DONE: done=1 for exactly one cycle, then go to IDLE; acc_j/acc_k hold until the next accepted start.
REQ-025 Latency: with start high in cycle 0, issues occur in cycles 1..N_INPUTS and done is high in cycle N_INPUTS+PIPE_LAT+1.
REQ-026 start while busy=1 (ISSUE, DRAIN or DONE) SHALL be ignored, not queued.
REQ-027 Back-to-back operation: start in the first IDLE cycle after DONE is accepted; the minimum start-to-start period is N_INPUTS+PIPE_LAT+2 cycles.
REQ-028 Without the macro, accumulation SHALL wrap modulo 2^ACC_W (two's complement).

Reset
REQ-029 reset=1 SHALL force IDLE and clear: index, rd_addr, valid shift register, acc_j, acc_k, sat; outputs issue_valid, busy, done = 0.
REQ-030 reset has priority over start in the same cycle.
REQ-031 Reset mid-ISSUE or mid-DRAIN discards in-flight products: none are accumulated after reset deasserts.
REQ-032 First start is accepted in the cycle after reset deasserts.

Configuration
REQ-033 Macro MACC_PAIR_SCHED_SAT_EN, when defined, SHALL clamp each accumulator to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on overflow and set sat (sticky until the next accepted start or reset).
REQ-034 When MACC_PAIR_SCHED_SAT_EN is not defined, the sat port and saturation logic SHALL be absent and REQ-028 applies.

Verification
Bench model: behavioural macc returning weight*input after PIPE_LAT cycles.
REQ-035 WIDTH=8, N_INPUTS=4, PIPE_LAT=3; all weight_j=10, weight_k=-10, input_i=1; start in cycle 0 -> done in cycle 8, acc_j=40, acc_k=-40, issue_valid high in cycles 1-4.
REQ-036 Defaults; input_i=-128, weight_j=-128, weight_k=127 for all 16 entries -> acc_j=262144, acc_k=-260096, no wrap.
REQ-037 start held high continuously -> exactly one done per 21 cycles (defaults); no start accepted while busy.
REQ-038 reset asserted in cycle 10 of an active run -> IDLE next cycle with all outputs zero; a new start then produces correct sums unpolluted by the aborted run.
REQ-039 ACC_W=16, weights 127, inputs 127, N_INPUTS=4 (true sum 64516): with macro, acc_j=32767 and sat=1; without macro, acc_j wraps to -1020.
REQ-040 rd_addr sequence checked as 0,1,2,...,N_INPUTS-1 with issue_valid, including N_INPUTS=2 and PIPE_LAT=1 corners.
